// File: rtl/cory_frame_pkg.sv
// cory_frame_pkg: header field positions, FSM state codes and helpers shared by the framer and deframer
package cory_frame_pkg;
   localparam int CORY_FRM_LEN_LSB = 0;
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BODY = 1'b1;
   function automatic int f_log2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/cory_frame_oreg.sv
// cory_frame_oreg: one-entry registered valid/ready output stage
module cory_frame_oreg #(parameter int W = 24) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         i_v,
   input  logic [W-1:0] i_d,
   input  logic         i_hdr,
   input  logic         i_last,
   output logic         o_ready,
   output logic         o_v,
   output logic [W-1:0] o_d,
   output logic         o_hdr,
   output logic         o_last,
   input  logic         i_r
);
   assign o_ready = !o_v | i_r;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         o_v    <= 1'b0;
         o_d    <= '0;
         o_hdr  <= 1'b0;
         o_last <= 1'b0;
      end else if (o_ready) begin
         o_v <= i_v;
         if (i_v) begin
            o_d    <= i_d;
            o_hdr  <= i_hdr;
            o_last <= i_last;
         end
      end
endmodule

// File: rtl/cory_frame.sv
// cory_frame: groups i_len input words into a frame led by a {seq, len} header beat
module cory_frame
   import cory_frame_pkg::*;
#(
   parameter int W  = 24,
   parameter int LW = 8,
   parameter int SW = 8
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          i_en,
   input  logic [LW-1:0] i_len,
   input  logic          i_a_v,
   input  logic [W-1:0]  i_a_d,
   output logic          o_a_r,
   output logic          o_z_v,
   output logic [W-1:0]  o_z_d,
   output logic          o_z_hdr,
   output logic          o_z_last,
   input  logic          i_z_r,
   output logic [SW-1:0] o_seq,
   output logic          o_busy
);
   localparam int CORY_FRM_SEQ_LSB = CORY_FRM_LEN_LSB + LW;
   logic [0:0]    state;
   logic [LW-1:0] cnt, len_q;
   logic [SW-1:0] seq_q;
   logic          can_load, hdr_load, a_vr, is_last;
   logic [W-1:0]  hdr_word;
   always_comb begin
      hdr_word = '0;
      hdr_word[CORY_FRM_LEN_LSB +: LW] = i_len;
      hdr_word[CORY_FRM_SEQ_LSB +: SW] = seq_q;
   end
   assign hdr_load = (state == ST_IDLE) & i_en & (|i_len) & can_load;
   assign o_a_r    = (state == ST_BODY) & can_load;
   assign a_vr     = i_a_v & o_a_r;
   assign is_last  = cnt == len_q - LW'(1);
   assign o_busy   = state == ST_BODY;
   assign o_seq    = seq_q;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
         len_q <= '0;
         seq_q <= '0;
      end else if (hdr_load) begin
         state <= ST_BODY;
         cnt   <= '0;
         len_q <= i_len;
      end else if (a_vr) begin
         cnt <= cnt + LW'(1);
         if (is_last) begin
            state <= ST_IDLE;
            seq_q <= seq_q + SW'(1);
         end
      end
   cory_frame_oreg #(.W(W)) u_oreg (
      .clk     (clk),
      .reset_n (reset_n),
      .i_v     (hdr_load | a_vr),
      .i_d     (hdr_load ? hdr_word : i_a_d),
      .i_hdr   (hdr_load),
      .i_last  (a_vr & is_last),
      .o_ready (can_load),
      .o_v     (o_z_v),
      .o_d     (o_z_d),
      .o_hdr   (o_z_hdr),
      .o_last  (o_z_last),
      .i_r     (i_z_r)
   );
endmodule

// File: tb/tb_cory_frame.sv
// tb_cory_frame: directed checks of cory_frame framing, backpressure, reset and sequence wrap
module tb_cory_frame;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        i_en = 1'b0;
   logic [7:0]  i_len = 8'd0;
   logic        i_a_v = 1'b0;
   logic [23:0] i_a_d = 24'd0;
   logic        i_z_r = 1'b1;
   logic        o_a_r, o_z_v, o_z_hdr, o_z_last, o_busy;
   logic [23:0] o_z_d;
   logic [7:0]  o_seq;
   logic        a2_r, z2_v, z2_hdr, z2_last, busy2;
   logic [23:0] z2_d;
   logic [1:0]  seq2;
   int          n_tests = 0;
   int          n_fail = 0;
   int          bad_ar = 0;
   int          n_unst = 0;
   logic        hold_p = 1'b0;
   logic [26:0] held = '0;
   logic [25:0] q[$];
   logic [25:0] q2[$];
   always #5 clk = ~clk;
   cory_frame #(.W(24), .LW(8), .SW(8)) dut (
      .clk(clk), .reset_n(reset_n), .i_en(i_en), .i_len(i_len), .i_a_v(i_a_v), .i_a_d(i_a_d),
      .o_a_r(o_a_r), .o_z_v(o_z_v), .o_z_d(o_z_d), .o_z_hdr(o_z_hdr), .o_z_last(o_z_last),
      .i_z_r(i_z_r), .o_seq(o_seq), .o_busy(o_busy)
   );
   cory_frame #(.W(24), .LW(8), .SW(2)) dut2 (
      .clk(clk), .reset_n(reset_n), .i_en(i_en), .i_len(i_len), .i_a_v(i_a_v), .i_a_d(i_a_d),
      .o_a_r(a2_r), .o_z_v(z2_v), .o_z_d(z2_d), .o_z_hdr(z2_hdr), .o_z_last(z2_last),
      .i_z_r(i_z_r), .o_seq(seq2), .o_busy(busy2)
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask
   task automatic chk_beat(input string tag, input logic hdr, input logic last, input logic [23:0] d);
      logic [25:0] b;
      b = (q.size() > 0) ? q.pop_front() : '1;
      chk(tag, {6'd0, b}, {6'd0, hdr, last, d});
   endtask
   // drive one cycle at the falling edge and record the beat the coming rising edge hands off
   task automatic cyc(input logic en, input logic av, input logic [23:0] d, input logic zr, output logic acc);
      @(negedge clk);
      i_en = en;
      i_a_v = av;
      i_a_d = d;
      i_z_r = zr;
      #1;
      acc = i_a_v && o_a_r;
      if (o_z_v && !i_z_r && o_a_r) bad_ar++;
      if (z2_v && !i_z_r && a2_r) bad_ar++;
      if (hold_p && {o_z_v, o_z_hdr, o_z_last, o_z_d} !== held) n_unst++;
      hold_p = o_z_v && !i_z_r;
      held = {o_z_v, o_z_hdr, o_z_last, o_z_d};
      if (o_z_v && i_z_r) q.push_back({o_z_hdr, o_z_last, o_z_d});
      if (z2_v && i_z_r) q2.push_back({z2_hdr, z2_last, z2_d});
   endtask
   task automatic run_stream(input int n_words, input int en_cycles, input logic toggle,
                             input logic [23:0] base, input int max_cyc);
      int   sent;
      logic acc;
      sent = 0;
      for (int c = 0; c < max_cyc; c++) begin
         cyc(c < en_cycles, sent < n_words, base + 24'(sent), toggle ? ((c % 2) == 0) : 1'b1, acc);
         if (acc) sent++;
      end
      i_a_v = 1'b0;
      i_en = 1'b0;
   endtask
   task automatic do_reset();
      @(negedge clk);
      i_en = 1'b0;
      i_a_v = 1'b0;
      i_z_r = 1'b1;
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      q.delete();
      q2.delete();
      hold_p = 1'b0;
   endtask
   initial begin
      int nbad;
      int nlast;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_z_v", {31'd0, o_z_v}, 32'd0);
      chk("rst_z_d", {8'd0, o_z_d}, 32'd0);
      chk("rst_hdr_last", {30'd0, o_z_hdr, o_z_last}, 32'd0);
      chk("rst_a_r", {31'd0, o_a_r}, 32'd0);
      chk("rst_seq", {24'd0, o_seq}, 32'd0);
      chk("rst_busy", {31'd0, o_busy}, 32'd0);
      do_reset();
      // T1: single frame of three words, i_en dropped after the header
      i_len = 8'd3;
      run_stream(3, 1, 1'b0, 24'h0000A1, 8);
      chk("t1_count", q.size(), 32'd4);
      chk_beat("t1_h", 1'b1, 1'b0, 24'h000003);
      chk_beat("t1_a1", 1'b0, 1'b0, 24'h0000A1);
      chk_beat("t1_a2", 1'b0, 1'b0, 24'h0000A2);
      chk_beat("t1_a3", 1'b0, 1'b1, 24'h0000A3);
      chk("t1_seq", {24'd0, o_seq}, 32'd1);
      chk("t1_idle", {31'd0, o_busy}, 32'd0);
      // T2: three back-to-back frames of two words within ten cycles
      do_reset();
      i_len = 8'd2;
      run_stream(6, 7, 1'b0, 24'h0000B0, 10);
      chk("t2_count", q.size(), 32'd9);
      chk_beat("t2_h0", 1'b1, 1'b0, 24'h000002);
      chk_beat("t2_w0", 1'b0, 1'b0, 24'h0000B0);
      chk_beat("t2_w1", 1'b0, 1'b1, 24'h0000B1);
      chk_beat("t2_h1", 1'b1, 1'b0, 24'h000102);
      chk_beat("t2_w2", 1'b0, 1'b0, 24'h0000B2);
      chk_beat("t2_w3", 1'b0, 1'b1, 24'h0000B3);
      chk_beat("t2_h2", 1'b1, 1'b0, 24'h000202);
      chk_beat("t2_w4", 1'b0, 1'b0, 24'h0000B4);
      chk_beat("t2_w5", 1'b0, 1'b1, 24'h0000B5);
      chk("t2_seq", {24'd0, o_seq}, 32'd3);
      // T3: alternating output backpressure on a four-word frame
      do_reset();
      i_len = 8'd4;
      bad_ar = 0;
      n_unst = 0;
      run_stream(4, 1, 1'b1, 24'h0000C0, 30);
      chk("t3_count", q.size(), 32'd5);
      chk_beat("t3_h", 1'b1, 1'b0, 24'h000004);
      chk_beat("t3_c0", 1'b0, 1'b0, 24'h0000C0);
      chk_beat("t3_c1", 1'b0, 1'b0, 24'h0000C1);
      chk_beat("t3_c2", 1'b0, 1'b0, 24'h0000C2);
      chk_beat("t3_c3", 1'b0, 1'b1, 24'h0000C3);
      chk("t3_ar_stall", bad_ar, 32'd0);
      chk("t3_stable", n_unst, 32'd0);
      chk("t3_seq", {24'd0, o_seq}, 32'd1);
      // T4: zero length yields nothing, maximum length yields 256 beats
      do_reset();
      i_len = 8'd0;
      run_stream(0, 5, 1'b0, 24'h0, 6);
      chk("t4_len0_count", q.size(), 32'd0);
      chk("t4_len0_busy", {31'd0, o_busy}, 32'd0);
      chk("t4_len0_zv", {31'd0, o_z_v}, 32'd0);
      i_len = 8'd255;
      run_stream(255, 1, 1'b0, 24'h0, 270);
      chk("t4_max_count", q.size(), 32'd256);
      chk_beat("t4_max_h", 1'b1, 1'b0, 24'h0000FF);
      nbad = 0;
      nlast = 0;
      for (int i = 0; i < 255; i++) begin
         logic [25:0] b;
         b = (q.size() > 0) ? q.pop_front() : '1;
         if (b[24]) nlast++;
         if (b !== {1'b0, i == 254, 24'(i)}) nbad++;
      end
      chk("t4_max_body", nbad, 32'd0);
      chk("t4_max_lasts", nlast, 32'd1);
      chk("t4_max_idle", {31'd0, o_busy}, 32'd0);
      // T5: asynchronous reset in the middle of a five-word frame
      do_reset();
      i_len = 8'd5;
      run_stream(2, 1, 1'b0, 24'h0000D0, 5);
      chk("t5_busy_pre", {31'd0, o_busy}, 32'd1);
      @(negedge clk);
      #3 reset_n = 1'b0;
      #1;
      chk("t5_async_zv", {31'd0, o_z_v}, 32'd0);
      chk("t5_async_zd", {8'd0, o_z_d}, 32'd0);
      chk("t5_async_ar", {31'd0, o_a_r}, 32'd0);
      chk("t5_async_busy", {31'd0, o_busy}, 32'd0);
      chk("t5_async_seq", {24'd0, o_seq}, 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      q.delete();
      q2.delete();
      hold_p = 1'b0;
      i_len = 8'd1;
      run_stream(1, 1, 1'b0, 24'h0000E0, 4);
      chk("t5_count", q.size(), 32'd2);
      chk_beat("t5_h", 1'b1, 1'b0, 24'h000001);
      chk_beat("t5_e0", 1'b0, 1'b1, 24'h0000E0);
      // T6: two-bit sequence wraps across five one-word frames
      do_reset();
      i_len = 8'd1;
      run_stream(5, 9, 1'b0, 24'h0000F0, 12);
      chk("t6_count", q2.size(), 32'd10);
      for (int k = 0; k < 5; k++) begin
         logic [25:0] h;
         logic [25:0] w;
         h = (q2.size() > 0) ? q2.pop_front() : '1;
         w = (q2.size() > 0) ? q2.pop_front() : '1;
         chk($sformatf("t6_h%0d", k), {6'd0, h}, {6'd0, 2'b10, 14'd0, 2'(k), 8'h01});
         chk($sformatf("t6_w%0d", k), {6'd0, w}, {6'd0, 2'b01, 24'h0000F0 + 24'(k)});
      end
      chk("t6_seq", {30'd0, seq2}, 32'd1);
      chk("t6_idle", {31'd0, busy2}, 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
